// File: rtl/fifo_pkg.sv
// Shared helpers for the width-converting single-clock FIFO.
package fifo_pkg;

    // Width of the storage word: the wider of the two ports.
    function automatic int unsigned wide_width(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width ratio between the two ports, always >= 1.
    function automatic int unsigned ratio(input int unsigned a, input int unsigned b);
        return (a > b) ? a / b : b / a;
    endfunction

    // True when one width is a power-of-two multiple of the other.
    function automatic bit ratio_ok(input int unsigned a, input int unsigned b);
        int unsigned hi;
        int unsigned lo;
        int unsigned q;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        if (lo == 0 || (hi % lo) != 0) begin
            return 1'b0;
        end
        q = hi / lo;
        return (q & (q - 1)) == 0;
    endfunction

endpackage

// File: rtl/sync_fifo_gearbox.sv
// Packer (upsize), unpacker (downsize) or passthrough between the ports and the storage core.
module sync_fifo_gearbox
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32,
    localparam int unsigned WIDE     = wide_width(IN_WIDTH, OUT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IN_WIDTH-1:0]  wr_data,
    input  logic                 push_ready,
    output logic                 push_valid,
    output logic [WIDE-1:0]      push_data,
    input  logic                 rd_en,
    input  logic                 pop_valid,
    output logic                 pop_ready,
    input  logic [WIDE-1:0]      pop_data,
    output logic                 out_avail,
    output logic [OUT_WIDTH-1:0] rd_data
);

    localparam int unsigned R    = ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned WR_R = (OUT_WIDTH > IN_WIDTH) ? R : 1;
    localparam int unsigned RD_R = (IN_WIDTH > OUT_WIDTH) ? R : 1;
    localparam int unsigned PW   = (WR_R > 1) ? $clog2(WR_R) : 1;
    localparam int unsigned UW   = (RD_R > 1) ? $clog2(RD_R) : 1;

    logic wr_accept;
    logic rd_accept;

    assign wr_accept = wr_en && push_ready;

    if (WR_R > 1) begin : g_pack
        logic [PW-1:0]   cnt_q;
        logic [WIDE-1:0] buf_q;

        // Current write lands in its slice; the last slice completes the word combinationally.
        always_comb begin
            push_data = buf_q;
            push_data[cnt_q*IN_WIDTH +: IN_WIDTH] = wr_data;
        end

        assign push_valid = wr_accept && (cnt_q == PW'(WR_R - 1));

        // Slice counter and partial word; counter wraps on the R-th write.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                buf_q <= '0;
            end else if (wr_accept) begin
                cnt_q <= cnt_q + 1'b1;
                buf_q <= push_data;
            end
        end
    end else begin : g_wr_direct
        assign push_data  = wr_data;
        assign push_valid = wr_accept;
    end

    if (RD_R > 1) begin : g_unpack
        logic [UW-1:0] left_q;
        logic [UW-1:0] sel_q;
        logic          pend_q;

        // A new storage word is only fetched once every slice of the previous one is consumed.
        assign out_avail = pop_valid || (left_q != '0);
        assign pop_ready = rd_en && (left_q == '0);
        assign rd_accept = rd_en && out_avail;

        // Slice tracking, then register the selected slice one edge after acceptance.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                left_q  <= '0;
                sel_q   <= '0;
                pend_q  <= 1'b0;
                rd_data <= '0;
            end else begin
                pend_q <= rd_accept;
                if (rd_accept) begin
                    if (left_q == '0) begin
                        sel_q  <= '0;
                        left_q <= UW'(RD_R - 1);
                    end else begin
                        sel_q  <= sel_q + 1'b1;
                        left_q <= left_q - 1'b1;
                    end
                end
                if (pend_q) begin
                    rd_data <= pop_data[sel_q*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end else begin : g_rd_direct
        logic pend_q;

        assign out_avail = pop_valid;
        assign pop_ready = rd_en;
        assign rd_accept = rd_en && pop_valid;

        // Output register follows the storage read register one edge later.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_q  <= 1'b0;
                rd_data <= '0;
            end else begin
                pend_q <= rd_accept;
                if (pend_q) begin
                    rd_data <= pop_data;
                end
            end
        end
    end

endmodule

// File: rtl/sync_gearbox_fifo.sv
// Single-clock FIFO with independent power-of-two-related write and read widths.
module sync_gearbox_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RESERVE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IN_WIDTH-1:0]   wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [OUT_WIDTH-1:0]  rd_data,
    output logic                  empty,
    output logic                  has_data,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int unsigned WIDE  = wide_width(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = LW'(DEPTH - RESERVE);

    if (!ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
        $error("sync_gearbox_fifo: widths must differ by a power-of-two ratio");
    end
    if (RESERVE >= DEPTH) begin : g_bad_reserve
        $error("sync_gearbox_fifo: RESERVE must be below DEPTH");
    end

    logic [ADDR_WIDTH:0] wr_ptr_q;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic [WIDE-1:0]     mem [DEPTH];
    logic [WIDE-1:0]     rd_word_q;
    logic [WIDE-1:0]     push_data;
    logic                push_valid;
    logic                push_ready;
    logic                pop_valid;
    logic                pop_ready;
    logic                push;
    logic                pop;
    logic                out_avail;

    // Extra pointer MSB separates a full array from an empty one.
    assign level      = wr_ptr_q - rd_ptr_q;
    assign full       = level >= FULL_LEVEL;
    assign push_ready = !full;
    assign pop_valid  = level != '0;
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign empty      = !out_avail;
    assign has_data   = out_avail;

    // Write/read pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= push_data;
        end
    end

    // Synchronous storage read port.
    always_ff @(posedge clk) begin
        if (pop) begin
            rd_word_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    sync_fifo_gearbox #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_gearbox (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .push_ready (push_ready),
        .push_valid (push_valid),
        .push_data  (push_data),
        .rd_en      (rd_en),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (rd_word_q),
        .out_avail  (out_avail),
        .rd_data    (rd_data)
    );

endmodule
